irq_sequencer: RTL and testbench

IRQ_SEQUENCER -- requirements
Module: irq_sequencer

---
 rtl/irq_sequencer.sv | 139 +++++++++++++
 tb/tb_irq_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_sequencer.sv
// irq_sequencer: synchronizes and edge-detects interrupt lines, latches pending flags, and sequences
//   entry (vector redirect), handler and return (saved-PC redirect) through the core's PC register.
// Latency: raw rise to redirect=1 is 4 edges; the core consumes the redirect on the 5th (stall=0).
// Backpressure: stall holds ENTER/RETURN with outputs stable and blocks new entries from IDLE.
// Ports: clk, reset (async, active-low); irq_raw/irq_mask [NSRC]; stall, irq_ret, pc_in[31:0];
//        redirect, redirect_pc[31:0], in_isr, irq_id[2:0], pending[NSRC].
module irq_sequencer #(
   parameter int          NSRC      = 4,
   parameter logic [31:0] VEC_BASE  = 32'h1000_0000,
   parameter int          VEC_SHIFT = 4
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_raw,
   input  logic [NSRC-1:0] irq_mask,
   input  logic            stall,
   input  logic            irq_ret,
   input  logic [31:0]     pc_in,
   output logic            redirect,
   output logic [31:0]     redirect_pc,
   output logic            in_isr,
   output logic [2:0]      irq_id,
   output logic [NSRC-1:0] pending
);

   typedef enum logic [1:0] {S_IDLE, S_ENTER, S_ISR, S_RETURN} state_t;

   state_t          state_q, state_d;
   logic [NSRC-1:0] sync1_q, sync1_d;
   logic [NSRC-1:0] sync2_q, sync2_d;
   logic [NSRC-1:0] hist_q, hist_d;
   logic [NSRC-1:0] pending_q, pending_d;
   logic [1:0]      warm_q, warm_d;
   logic [2:0]      irq_id_q, irq_id_d;
   logic [31:0]     lr_q, lr_d;

   logic [NSRC-1:0] edge_det;
   logic [NSRC-1:0] eligible;
   logic [NSRC-1:0] win_oh;
   logic [NSRC-1:0] clr;
   logic [2:0]      winner;
   logic            found;
   logic [31:0]     vec_addr;

   // Input conditioning and fixed-priority winner selection.
   always_comb begin
      sync1_d  = irq_raw;
      sync2_d  = sync1_q;
      hist_d   = sync2_q;
      // hist_q only holds a real sample of the line from the third edge after reset.
      // Until then edges are suppressed, so a line already high at release is not taken.
      warm_d   = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
      edge_det = (warm_q == 2'd3) ? (sync2_q & ~hist_q) : '0;
      eligible = pending_q & irq_mask;
      found    = 1'b0;
      winner   = '0;
      win_oh   = '0;
      for (int i = 0; i < NSRC; i++) begin
         if (eligible[i] && !found) begin
            found     = 1'b1;
            winner    = 3'(i);
            win_oh[i] = 1'b1;
         end
      end
      // 32-bit sum: overflow wraps silently.
      vec_addr = VEC_BASE + ({29'd0, irq_id_q} << VEC_SHIFT);
   end

   // Sequencer next-state and Moore outputs.
   always_comb begin
      state_d     = state_q;
      irq_id_d    = irq_id_q;
      lr_d        = lr_q;
      clr         = '0;
      redirect    = 1'b0;
      redirect_pc = '0;
      in_isr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (found && !stall) begin
               state_d  = S_ENTER;
               irq_id_d = winner;
               clr      = win_oh;
            end
         end
         S_ENTER: begin
            redirect    = 1'b1;
            redirect_pc = vec_addr;
            if (!stall) begin
               lr_d    = pc_in;
               state_d = S_ISR;
            end
         end
         S_ISR: begin
            in_isr = 1'b1;
            if (irq_ret && !stall) begin
               state_d = S_RETURN;
            end
         end
         S_RETURN: begin
            in_isr      = 1'b1;
            redirect    = 1'b1;
            redirect_pc = lr_q;
            if (!stall) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      // A fresh edge on the bit being taken keeps it pending (set beats clear).
      pending_d = (pending_q & ~clr) | edge_det;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         sync1_q   <= '0;
         sync2_q   <= '0;
         hist_q    <= '0;
         pending_q <= '0;
         warm_q    <= '0;
         irq_id_q  <= '0;
         lr_q      <= '0;
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         hist_q    <= hist_d;
         pending_q <= pending_d;
         warm_q    <= warm_d;
         irq_id_q  <= irq_id_d;
         lr_q      <= lr_d;
      end
   end

   assign pending = pending_q;
   assign irq_id  = irq_id_q;

endmodule

// File: tb/tb_irq_sequencer.sv
// tb_irq_sequencer: directed scenarios plus randomized traffic for irq_sequencer, checked every
//   cycle against a transaction-level model of the interrupt sequencing rules.
module tb_irq_sequencer;
   localparam int          NSRC = 4;
   localparam logic [31:0] VB   = 32'h1000_0000;
   localparam int          VS   = 4;

   logic            clk   = 1'b0;
   logic            reset = 1'b1;
   logic [NSRC-1:0] irq_raw  = '0;
   logic [NSRC-1:0] irq_mask = '0;
   logic            stall    = 1'b0;
   logic            irq_ret  = 1'b0;
   logic [31:0]     pc_in    = '0;
   logic            redirect;
   logic [31:0]     redirect_pc;
   logic            in_isr;
   logic [2:0]      irq_id;
   logic [NSRC-1:0] pending;

   irq_sequencer #(.NSRC(NSRC), .VEC_BASE(VB), .VEC_SHIFT(VS)) dut (
      .clk(clk), .reset(reset), .irq_raw(irq_raw), .irq_mask(irq_mask), .stall(stall),
      .irq_ret(irq_ret), .pc_in(pc_in), .redirect(redirect), .redirect_pc(redirect_pc),
      .in_isr(in_isr), .irq_id(irq_id), .pending(pending)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h at %0t", name, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   localparam int P_IDLE = 0, P_ENTER = 1, P_ISR = 2, P_RET = 3;
   int              m_phase = P_IDLE;
   logic [NSRC-1:0] m_pend  = '0;
   logic [2:0]      m_id    = '0;
   logic [31:0]     m_lr    = '0;
   logic [NSRC-1:0] m_samp[$];
   int              m_nedge = 0;   // clock edges seen since reset release

   task automatic model_step();
      logic [NSRC-1:0] new_edges, elig, low, clr;
      // The line is sampled every edge; it counts as risen when the sample two edges back is 1
      // and the one three edges back is 0 (two sync stages, one edge-history stage).
      m_samp.push_back(irq_raw);
      m_nedge++;
      new_edges = '0;
      if (m_nedge >= 4)
         new_edges = m_samp[m_samp.size()-3] & ~m_samp[m_samp.size()-4];
      if (m_samp.size() > 4) void'(m_samp.pop_front());
      clr = '0;
      case (m_phase)
         P_IDLE: begin
            elig = m_pend & irq_mask;
            if (elig != 0 && !stall) begin
               low     = elig & (~elig + 1'b1);   // isolate lowest set bit
               m_id    = 3'($clog2(low));
               clr     = low;
               m_phase = P_ENTER;
            end
         end
         P_ENTER: if (!stall) begin m_lr = pc_in; m_phase = P_ISR; end
         P_ISR:   if (irq_ret && !stall) m_phase = P_RET;
         default: if (!stall) m_phase = P_IDLE;
      endcase
      m_pend = (m_pend & ~clr) | new_edges;
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_phase = P_IDLE; m_pend = '0; m_id = '0; m_lr = '0; m_nedge = 0;
         m_samp.delete();
      end else begin
         model_step();
      end
   end

   // Per-cycle compare against the model.
   initial forever begin
      logic        e_red, e_isr;
      logic [31:0] e_pc;
      @(negedge clk);
      e_red = (m_phase == P_ENTER) || (m_phase == P_RET);
      e_isr = (m_phase == P_ISR) || (m_phase == P_RET);
      e_pc  = (m_phase == P_ENTER) ? VB + 32'(m_id) * (32'd1 << VS) :
              (m_phase == P_RET)   ? m_lr : 32'd0;
      chk("cmp_redirect", 32'(redirect), 32'(e_red));
      chk("cmp_redirect_pc", redirect_pc, e_pc);
      chk("cmp_in_isr", 32'(in_isr), 32'(e_isr));
      chk("cmp_irq_id", 32'(irq_id), 32'(m_id));
      chk("cmp_pending", 32'(pending), 32'(m_pend));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic do_reset();
      reset = 1'b0; irq_raw = '0; stall = 1'b0; irq_ret = 1'b0;
      #1;
      chk("rst_redirect", 32'(redirect), 32'd0);
      chk("rst_pc", redirect_pc, 32'd0);
      chk("rst_in_isr", 32'(in_isr), 32'd0);
      chk("rst_pending", 32'(pending), 32'd0);
      ticks(2);
      reset = 1'b1;
      ticks(4);
   endtask

   task automatic wait_redirect(input string name);
      int n = 0;
      while (redirect !== 1'b1 && n < 40) begin tick(); n++; end
      chk(name, 32'(redirect), 32'd1);
   endtask

   // From ENTER: take the vector, run the handler, return to ret_pc and land in IDLE.
   task automatic service(input logic [31:0] ret_pc);
      pc_in = ret_pc; stall = 1'b0;
      tick();
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      chk("svc_ret_pc", redirect_pc, ret_pc);
      tick();
   endtask

   initial begin
      #1;
      do_reset();
      irq_mask = 4'hF;

      // Single source: 4 edges to redirect, vector 0x10000020, then return to 0x40.
      irq_raw = 4'b0100;
      ticks(3);
      chk("t1_pending_set", 32'(pending), 32'h4);
      chk("t1_no_redirect_yet", 32'(redirect), 32'd0);
      tick();
      chk("t1_redirect", 32'(redirect), 32'd1);
      chk("t1_vec", redirect_pc, 32'h1000_0020);
      chk("t1_id", 32'(irq_id), 32'd2);
      chk("t1_pending_clr", 32'(pending), 32'h0);
      pc_in = 32'h40;
      tick();
      chk("t1_in_isr", 32'(in_isr), 32'd1);
      chk("t1_isr_no_redirect", 32'(redirect), 32'd0);
      irq_raw = '0;
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      chk("t1_ret_pc", redirect_pc, 32'h40);
      tick();
      chk("t1_isr_off", 32'(in_isr), 32'd0);

      // Simultaneous sources 3 and 1: 1 first, 3 back-to-back.
      irq_raw = 4'b1010;
      wait_redirect("t2_reach");
      chk("t2_vec1", redirect_pc, 32'h1000_0010);
      irq_raw = '0;
      service(32'h80);
      chk("t2_idle_pending", 32'(pending), 32'h8);
      tick();
      chk("t2_vec3", redirect_pc, 32'h1000_0030);
      chk("t2_id3", 32'(irq_id), 32'd3);
      service(32'h90);

      // Masked source waits pending, then is taken when unmasked.
      irq_mask = 4'b1110;
      irq_raw  = 4'b0001;
      ticks(8);
      chk("t3_pending", 32'(pending), 32'h1);
      chk("t3_no_redirect", 32'(redirect), 32'd0);
      irq_raw  = '0;
      irq_mask = 4'hF;
      tick();
      chk("t3_vec0", redirect_pc, 32'h1000_0000);
      service(32'hA0);

      // Stall in ENTER: vector stable, LR takes pc_in only on the unstalled edge.
      irq_raw = 4'b0010;
      wait_redirect("t4_reach");
      irq_raw = '0; stall = 1'b1; pc_in = 32'h111;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("t4_stall_vec", redirect_pc, 32'h1000_0010);
      end
      pc_in = 32'h222; stall = 1'b0;
      tick();
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      chk("t4_lr", redirect_pc, 32'h222);
      tick();

      // irq_ret in IDLE ignored; repeat edges during ISR give exactly one re-entry.
      irq_ret = 1'b1;
      ticks(2);
      chk("t5_ret_idle_redirect", 32'(redirect), 32'd0);
      chk("t5_ret_idle_isr", 32'(in_isr), 32'd0);
      irq_ret = 1'b0;
      irq_raw = 4'b0001;
      wait_redirect("t5_reach");
      pc_in = 32'hB0;
      tick();
      irq_raw = 4'b0000; ticks(3);
      irq_raw = 4'b0001; ticks(3);
      irq_raw = 4'b0000; ticks(3);
      irq_raw = 4'b0001; ticks(3);
      irq_raw = 4'b0000; ticks(4);
      chk("t5_pending_flag", 32'(pending), 32'h1);
      irq_ret = 1'b1;
      tick();
      irq_ret = 1'b0;
      tick();
      tick();
      chk("t5_reentry", redirect_pc, 32'h1000_0000);
      service(32'hC0);
      ticks(10);
      chk("t5_no_second", 32'(pending), 32'h0);
      chk("t5_idle", 32'(redirect), 32'd0);

      // Reset mid-ISR clears everything at once; a line held high across release is not taken.
      irq_raw = 4'b0100;
      wait_redirect("t6_reach");
      tick();
      chk("t6_in_isr", 32'(in_isr), 32'd1);
      reset = 1'b0;
      #1;
      chk("t6_rst_isr", 32'(in_isr), 32'd0);
      chk("t6_rst_id", 32'(irq_id), 32'd0);
      chk("t6_rst_redirect", 32'(redirect), 32'd0);
      ticks(2);
      reset = 1'b1;
      ticks(10);
      chk("t6_held_pending", 32'(pending), 32'h0);
      chk("t6_held_redirect", 32'(redirect), 32'd0);
      irq_raw = '0;
      ticks(4);

      // Randomized traffic, checked by the per-cycle compare.
      for (int c = 0; c < 4000; c++) begin
         for (int b = 0; b < NSRC; b++)
            if ($urandom_range(0, 15) == 0) irq_raw[b] = ~irq_raw[b];
         if ($urandom_range(0, 31) == 0) irq_mask = 4'($urandom);
         stall   = ($urandom_range(0, 3) == 0);
         irq_ret = ($urandom_range(0, 4) == 0);
         pc_in   = $urandom;
         reset   = ($urandom_range(0, 999) != 0);
         tick();
      end
      reset = 1'b1;
      ticks(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
